mux_scan_ctrl: RTL and testbench

- Upstream sequencer for the 4:1 decoder/tri-state mux; drives its 2-bit select and captures its output.
- Steps the select through channels 0..3, waits a programmable settle time on each, samples the mux output and assembles a 4-bit frame.
- Presents each frame on a valid/ready handshake.
- Holds one completed frame plus one in-progress frame, so scanning overlaps with a consumer stall.

---
 rtl/mux_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 decoder/tri-state mux: steps the select, samples
// its output per channel and hands each 4-bit frame off on valid/ready.
module mux_scan_ctrl #(
   parameter int SETTLE = 2,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cont,
   input  logic             y,
   output logic [1:0]       s,
   output logic [3:0]       frame,
   output logic             valid,
   input  logic             ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_WAIT
   } state_t;

   // With no settle time every channel goes straight to its sample cycle.
   localparam logic [CNT_W-1:0] RELOAD     = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);
   localparam state_t           SCAN_ENTRY = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

   state_t           state, state_next;
   logic [1:0]       s_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [3:0]       shadow, shadow_next;
   logic [3:0]       frame_next;
   logic             valid_next;
   logic             take;

   assign take = valid && ready;
   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         s      <= 2'd0;
         cnt    <= '0;
         shadow <= 4'd0;
         frame  <= 4'd0;
         valid  <= 1'b0;
      end else begin
         state  <= state_next;
         s      <= s_next;
         cnt    <= cnt_next;
         shadow <= shadow_next;
         frame  <= frame_next;
         valid  <= valid_next;
      end
   end

   always_comb begin
      state_next  = state;
      s_next      = s;
      cnt_next    = cnt;
      shadow_next = shadow;
      frame_next  = frame;
      valid_next  = valid;

      // A transfer empties the output register unless a new frame loads below.
      if (take) begin
         valid_next = 1'b0;
      end

      case (state)
         ST_IDLE: begin
            s_next = 2'd0;
            if (start || cont) begin
               state_next = SCAN_ENTRY;
               cnt_next   = RELOAD;
            end
         end

         ST_SETTLE: begin
            if (cnt == '0) begin
               state_next = ST_SAMPLE;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end

         ST_SAMPLE: begin
            shadow_next[s] = y;
            if (s != 2'd3) begin
               s_next     = s + 2'd1;
               cnt_next   = RELOAD;
               state_next = SCAN_ENTRY;
            end else if (!valid || take) begin
               frame_next = shadow_next;
               valid_next = 1'b1;
               s_next     = 2'd0;
               if (cont) begin
                  state_next = SCAN_ENTRY;
                  cnt_next   = RELOAD;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               state_next = ST_WAIT;
            end
         end

         ST_WAIT: begin
            // Completed frame is parked in shadow until the consumer takes the old one.
            if (take) begin
               frame_next = shadow;
               valid_next = 1'b1;
               s_next     = 2'd0;
               if (cont) begin
                  state_next = SCAN_ENTRY;
                  cnt_next   = RELOAD;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: a cycle table for the basic scan plus
// directed sequences for stalls, zero settle, ignored start, reset and streaming.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic       ready = 1'b0;
   logic [3:0] mux_in = 4'd0;

   logic       y, y0;
   logic [1:0] s, s0;
   logic [3:0] frame, frame0;
   logic       valid, valid0, busy, busy0;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic       start;
      logic       cont;
      logic       ready;
      logic [1:0] exp_s;
      logic       exp_valid;
      logic       exp_busy;
      logic [3:0] exp_frame;
   } vec_t;

   vec_t vecs[14];

   always #5 clk = ~clk;

   // Mux model: decoder a=s[1], b=s[0] enables input i[{a,b}].
   assign y  = mux_in[s];
   assign y0 = mux_in[s0];

   mux_scan_ctrl #(.SETTLE(2), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .y(y),
      .s(s), .frame(frame), .valid(valid), .ready(ready), .busy(busy)
   );

   mux_scan_ctrl #(.SETTLE(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .y(y0),
      .s(s0), .frame(frame0), .valid(valid0), .ready(ready), .busy(busy0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic co, input logic rd);
      start = st;
      cont  = co;
      ready = rd;
      tick();
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic doReset();
      start = 1'b0;
      cont  = 1'b0;
      ready = 1'b0;
      #2 rst_n = 1'b0;
      #10 rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [7:0] pack(input logic [1:0] ss, input logic v, input logic b, input logic [3:0] f);
      return {ss, v, b, f};
   endfunction

   initial begin
      int vcount;
      logic [3:0] got_frame;

      vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'h0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'h0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'h0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 4'h0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 4'h0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 4'h0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'h0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'h0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'h0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 4'h0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 4'h0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 4'h0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'hA};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'hA};

      doReset();
      checkOutput("reset_state", pack(s, valid, busy, frame), 8'h00);
      checkOutput("reset_state_s0", pack(s0, valid0, busy0, frame0), 8'h00);

      // Single scan, SETTLE=2, i=1010
      mux_in = 4'b1010;
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].start, vecs[i].cont, vecs[i].ready);
         checkOutput($sformatf("scan_row%0d", i), pack(s, valid, busy, frame),
                     pack(vecs[i].exp_s, vecs[i].exp_valid, vecs[i].exp_busy, vecs[i].exp_frame));
      end

      // Continuous mode with a stalled consumer
      doReset();
      mux_in = 4'b1010;
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("stall_first_ch3", pack(s, valid, busy, frame), pack(2'd3, 1'b0, 1'b1, 4'h0));
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("stall_first_frame", pack(s, valid, busy, frame), pack(2'd0, 1'b1, 1'b1, 4'hA));
      mux_in = 4'b0110;
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("stall_enter_wait", pack(s, valid, busy, frame), pack(2'd3, 1'b1, 1'b1, 4'hA));
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("stall_hold_wait", pack(s, valid, busy, frame), pack(2'd3, 1'b1, 1'b1, 4'hA));
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("stall_release", pack(s, valid, busy, frame), pack(2'd0, 1'b1, 1'b1, 4'h6));
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("stall_third_scan", pack(s, valid, busy, frame), pack(2'd0, 1'b1, 1'b1, 4'h6));

      // Zero settle time on the second instance
      doReset();
      mux_in = 4'b0001;
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("zero_e0", pack(s0, valid0, busy0, frame0), pack(2'd0, 1'b0, 1'b1, 4'h0));
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("zero_e1", pack(s0, valid0, busy0, frame0), pack(2'd1, 1'b0, 1'b1, 4'h0));
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("zero_e2", pack(s0, valid0, busy0, frame0), pack(2'd2, 1'b0, 1'b1, 4'h0));
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("zero_e3", pack(s0, valid0, busy0, frame0), pack(2'd3, 1'b0, 1'b1, 4'h0));
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("zero_e4", pack(s0, valid0, busy0, frame0), pack(2'd0, 1'b1, 1'b0, 4'h1));
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("zero_e5", pack(s0, valid0, busy0, frame0), pack(2'd0, 1'b0, 1'b0, 4'h1));

      // Start while busy is ignored
      doReset();
      mux_in = 4'b1010;
      applyStimulus(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("busy_start_at_s1", {6'd0, s}, 8'd1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      vcount = 0;
      got_frame = 4'd0;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         if (valid) begin
            vcount++;
            got_frame = frame;
         end
      end
      checkOutput("busy_start_frames", 8'(vcount), 8'd1);
      checkOutput("busy_start_data", {4'd0, got_frame}, 8'h0A);
      checkOutput("busy_start_idle", {7'd0, busy}, 8'd0);

      // Dropping cont mid-scan finishes the frame and stops
      doReset();
      mux_in = 4'b1010;
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("drop_cont_at_s2", {6'd0, s}, 8'd2);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("drop_cont_frame", pack(s, valid, busy, frame), pack(2'd0, 1'b1, 1'b0, 4'hA));
      vcount = 0;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         if (valid) vcount++;
      end
      checkOutput("drop_cont_no_more", pack(2'd0, 1'b0, busy, 4'(vcount)), 8'h00);

      // Asynchronous reset mid-scan, then a clean scan
      doReset();
      mux_in = 4'b1010;
      for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("areset_pre_frame", pack(s, valid, busy, frame), pack(2'd0, 1'b1, 1'b1, 4'hA));
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("areset_pre_s2", {6'd0, s}, 8'd2);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("areset_immediate", pack(s, valid, busy, frame), 8'h00);
      cont = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      mux_in = 4'b0101;
      applyStimulus(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("areset_before_done", {7'd0, valid}, 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("areset_rescan", pack(s, valid, busy, frame), pack(2'd0, 1'b1, 1'b0, 4'h5));

      // Back-to-back continuous frames with alternating data
      doReset();
      mux_in = 4'b1111;
      vcount = 0;
      applyStimulus(1'b0, 1'b1, 1'b1);
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (valid) vcount++;
         end
         applyStimulus(1'b0, 1'b1, 1'b1);
         if (valid) vcount++;
         checkOutput($sformatf("stream_frame%0d", f), pack(s, valid, busy, frame),
                     pack(2'd0, 1'b1, 1'b1, (f % 2 == 0) ? 4'hF : 4'h0));
         mux_in = ~mux_in;
      end
      checkOutput("stream_pulses", 8'(vcount), 8'd4);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
